// File: rtl/register_file_param.sv
// Parametrised general/scratch register file: NUM_R+NUM_S registers of WIDTH bits, shared FunSel ops, sticky wrap flags, zero flags.
// Optional RF_BYPASS_EN: reads of a register enabled this cycle show its next-edge value.
module register_file_param #(
  parameter  int WIDTH = 32,
  parameter  int NUM_R = 4,
  parameter  int NUM_S = 4,
  localparam int SEL_W = $clog2(NUM_R + NUM_S)
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic [WIDTH-1:0]         I,
  input  logic [2:0]               FunSel,
  input  logic [NUM_R-1:0]         RegSel,
  input  logic [NUM_S-1:0]         ScrSel,
  input  logic [SEL_W-1:0]         OutASel,
  input  logic [SEL_W-1:0]         OutBSel,
  input  logic                     WrapClr,
  output logic [WIDTH-1:0]         OutA,
  output logic [WIDTH-1:0]         OutB,
  output logic                     ZeroA,
  output logic                     ZeroB,
  output logic [NUM_R+NUM_S-1:0]   Wrap
);

  localparam int N    = NUM_R + NUM_S;
  localparam int HALF = WIDTH / 2;
  localparam int NSEL = 2 ** SEL_W;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q    [N];
  logic [N-1:0]     r_wrap;
  logic [N-1:0]     w_en;
  logic [N-1:0]     w_wrap_set;
  logic [WIDTH-1:0] w_nxt  [N];
  logic [WIDTH-1:0] w_view [N];
  logic [WIDTH-1:0] w_rd   [NSEL];

  // Internal index equals the read select code; enable vectors are MSB-first.
  for (genvar k = 0; k < NUM_R; k++) begin : g_ren
    assign w_en[k] = RegSel[NUM_R-1-k];
  end
  for (genvar k = 0; k < NUM_S; k++) begin : g_sen
    assign w_en[NUM_R+k] = ScrSel[NUM_S-1-k];
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_nxt[k]      = r_q[k];
      w_wrap_set[k] = 1'b0;
      case (FunSel)
        3'b000: begin
          w_nxt[k]      = r_q[k] - ONE;
          w_wrap_set[k] = w_en[k] && (r_q[k] == '0);
        end
        3'b001: begin
          w_nxt[k]      = r_q[k] + ONE;
          w_wrap_set[k] = w_en[k] && (r_q[k] == '1);
        end
        3'b010:  w_nxt[k] = I;
        3'b011:  w_nxt[k] = '0;
        3'b100:  w_nxt[k] = {{(WIDTH-8){1'b0}}, I[7:0]};
        3'b101:  w_nxt[k] = {{HALF{1'b0}}, I[HALF-1:0]};
        3'b110:  w_nxt[k] = {r_q[k][WIDTH-9:0], I[7:0]};
        default: w_nxt[k] = {{HALF{I[HALF-1]}}, I[HALF-1:0]};
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int k = 0; k < N; k++) r_q[k] <= '0;
      r_wrap <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_en[k]) r_q[k] <= w_nxt[k];
      end
      // Set has priority over clear when both land on the same edge.
      r_wrap <= w_wrap_set | (r_wrap & ~{N{WrapClr}});
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_view
`ifdef RF_BYPASS_EN
    assign w_view[k] = w_en[k] ? (nReset ? w_nxt[k] : '0) : r_q[k];
`else
    assign w_view[k] = r_q[k];
`endif
  end

  // Pad the read table to the full select range so unused codes read as 0.
  for (genvar k = 0; k < NSEL; k++) begin : g_rd
    if (k < N) begin : g_live
      assign w_rd[k] = w_view[k];
    end else begin : g_pad
      assign w_rd[k] = '0;
    end
  end

  assign OutA  = w_rd[OutASel];
  assign OutB  = w_rd[OutBSel];
  assign ZeroA = (OutA == '0);
  assign ZeroB = (OutB == '0);
  assign Wrap  = r_wrap;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default 32-bit 4+4 instance and a 16-bit 3+2 instance.
module tb_register_file_param;

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Default instance: WIDTH=32, NUM_R=4, NUM_S=4, SEL_W=3
  logic        nReset;
  logic [31:0] I;
  logic [2:0]  FunSel;
  logic [3:0]  RegSel, ScrSel;
  logic [2:0]  OutASel, OutBSel;
  logic        WrapClr;
  logic [31:0] OutA, OutB;
  logic        ZeroA, ZeroB;
  logic [7:0]  Wrap;

  register_file_param u_dut (
    .Clock(Clock), .nReset(nReset), .I(I), .FunSel(FunSel),
    .RegSel(RegSel), .ScrSel(ScrSel), .OutASel(OutASel), .OutBSel(OutBSel),
    .WrapClr(WrapClr), .OutA(OutA), .OutB(OutB), .ZeroA(ZeroA), .ZeroB(ZeroB),
    .Wrap(Wrap)
  );

  // Small instance: WIDTH=16, NUM_R=3, NUM_S=2, SEL_W=3
  logic [15:0] s_I;
  logic [2:0]  s_FunSel;
  logic [2:0]  s_RegSel;
  logic [1:0]  s_ScrSel;
  logic [2:0]  s_OutASel, s_OutBSel;
  logic        s_WrapClr;
  logic [15:0] s_OutA, s_OutB;
  logic        s_ZeroA, s_ZeroB;
  logic [4:0]  s_Wrap;

  register_file_param #(.WIDTH(16), .NUM_R(3), .NUM_S(2)) u_small (
    .Clock(Clock), .nReset(nReset), .I(s_I), .FunSel(s_FunSel),
    .RegSel(s_RegSel), .ScrSel(s_ScrSel), .OutASel(s_OutASel), .OutBSel(s_OutBSel),
    .WrapClr(s_WrapClr), .OutA(s_OutA), .OutB(s_OutB), .ZeroA(s_ZeroA), .ZeroB(s_ZeroB),
    .Wrap(s_Wrap)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One write edge on the default instance, enables dropped afterwards.
  task automatic wr(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] fs,
                    input logic [31:0] d, input logic clr);
    RegSel = rs; ScrSel = ss; FunSel = fs; I = d; WrapClr = clr;
    tick();
    RegSel = '0; ScrSel = '0; WrapClr = 1'b0;
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    OutASel = a; OutBSel = b;
    #1;
  endtask

  initial begin
    nReset = 1'b1; I = '0; FunSel = '0; RegSel = '0; ScrSel = '0;
    OutASel = '0; OutBSel = '0; WrapClr = 1'b0;
    s_I = '0; s_FunSel = '0; s_RegSel = '0; s_ScrSel = '0;
    s_OutASel = '0; s_OutBSel = '0; s_WrapClr = 1'b0;
    #2;

    // 1. random preload, then reset with everything else active
    wr(4'hF, 4'hF, 3'b010, $urandom | 32'h1, 1'b0);
    nReset = 1'b0;
    RegSel = 4'hF; ScrSel = 4'hF; FunSel = 3'b001; WrapClr = 1'b0;
    s_RegSel = 3'b111; s_ScrSel = 2'b11; s_FunSel = 3'b010; s_I = 16'hBEEF;
    tick();
    nReset = 1'b1; RegSel = '0; ScrSel = '0; s_RegSel = '0; s_ScrSel = '0;
    #1;
    for (int k = 0; k < 8; k++) begin
      rd(k[2:0], k[2:0]);
      check($sformatf("rst_outa_%0d", k), OutA, 32'h0);
    end
    check("rst_zeroa", {31'b0, ZeroA}, 32'h1);
    check("rst_zerob", {31'b0, ZeroB}, 32'h1);
    check("rst_wrap", {24'b0, Wrap}, 32'h0);
    check("rst_small_wrap", {27'b0, s_Wrap}, 32'h0);

    // 2. load R1, then shift-in a byte
    wr(4'b1000, 4'b0000, 3'b010, 32'h12345678, 1'b0);
    rd(3'd0, 3'd0);
    check("r1_load", OutA, 32'h12345678);
    check("r1_load_zero", {31'b0, ZeroA}, 32'h0);
    wr(4'b1000, 4'b0000, 3'b110, 32'h000000AB, 1'b0);
    rd(3'd0, 3'd0);
    check("r1_shl8", OutA, 32'h345678AB);

    // 3. R2 decrement wrap, set-wins, then clear
    wr(4'b0100, 4'b0000, 3'b000, 32'h0, 1'b0);
    rd(3'd0, 3'd1);
    check("r2_dec_wrap", OutB, 32'hFFFFFFFF);
    check("wrap_set_dec", {24'b0, Wrap}, 32'h02);
    wr(4'b0100, 4'b0000, 3'b001, 32'h0, 1'b1);
    check("r2_inc_wrap", OutB, 32'h0);
    check("r2_zero_b", {31'b0, ZeroB}, 32'h1);
    check("wrap_set_wins", {24'b0, Wrap}, 32'h02);
    wr(4'b0000, 4'b0000, 3'b001, 32'h0, 1'b1);
    check("wrap_cleared", {24'b0, Wrap}, 32'h0);

    // multiple enables act independently; non-wrapping ops leave flags alone
    wr(4'b1100, 4'b0000, 3'b001, 32'h0, 1'b0);
    rd(3'd0, 3'd1);
    check("multi_r1", OutA, 32'h345678AC);
    check("multi_r2", OutB, 32'h00000001);
    check("multi_nowrap", {24'b0, Wrap}, 32'h0);
    wr(4'b0000, 4'b0000, 3'b011, 32'h0, 1'b0);
    check("hold_r1", OutA, 32'h345678AC);

    // 4. S3 (code 6) sign-extend, zero-extend half, zero-extend byte, clear
    wr(4'b0000, 4'b0010, 3'b111, 32'h00008001, 1'b0);
    rd(3'd6, 3'd6);
    check("s3_sext", OutA, 32'hFFFF8001);
    wr(4'b0000, 4'b0010, 3'b101, 32'h00008001, 1'b0);
    check("s3_zext_half", OutA, 32'h00008001);
    wr(4'b0000, 4'b0010, 3'b100, 32'h00008001, 1'b0);
    check("s3_zext_byte", OutA, 32'h00000001);
    wr(4'b0000, 4'b0010, 3'b011, 32'h0, 1'b0);
    check("s3_clear", OutA, 32'h0);
    check("s3_clear_zero", {31'b0, ZeroA}, 32'h1);

    // S1 (code 4) increment wrap sets flag bit 4
    wr(4'b0000, 4'b1000, 3'b010, 32'hFFFFFFFF, 1'b0);
    wr(4'b0000, 4'b1000, 3'b001, 32'h0, 1'b0);
    rd(3'd4, 3'd0);
    check("s1_inc_wrap", OutA, 32'h0);
    check("s1_wrap_flag", {24'b0, Wrap}, 32'h10);

    // 5. small instance: S2 = code 4, codes 5..7 read 0
    s_ScrSel = 2'b01; s_FunSel = 3'b010; s_I = 16'h1234;
    tick();
    s_ScrSel = 2'b00;
    s_OutASel = 3'd7; s_OutBSel = 3'd4;
    #1;
    check("small_oob_a", {16'b0, s_OutA}, 32'h0);
    check("small_oob_zero", {31'b0, s_ZeroA}, 32'h1);
    check("small_s2_b", {16'b0, s_OutB}, 32'h1234);
    s_ScrSel = 2'b01; s_FunSel = 3'b110; s_I = 16'h00CD;
    tick();
    s_FunSel = 3'b111; s_I = 16'h0080;
    s_RegSel = 3'b100;
    #1;
    check("small_s2_shl8", {16'b0, s_OutB}, 32'h34CD);
    s_ScrSel = 2'b00;
    tick();
    s_RegSel = 3'b000; s_OutASel = 3'd0;
    #1;
    check("small_r1_sext", {16'b0, s_OutA}, 32'hFF80);
    s_OutASel = 3'd5;
    #1;
    check("small_code5", {16'b0, s_OutA}, 32'h0);

    // 6. same-cycle visibility of an R4 increment
    wr(4'b0001, 4'b0000, 3'b010, 32'h5, 1'b0);
    RegSel = 4'b0001; FunSel = 3'b001; OutASel = 3'd3;
    #1;
`ifdef RF_BYPASS_EN
    check("r4_same_cycle", OutA, 32'h6);
`else
    check("r4_same_cycle", OutA, 32'h5);
`endif
    tick();
    RegSel = '0;
    #1;
    check("r4_after_edge", OutA, 32'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
